// File: rtl/accumulator_bank_pkg.sv
// -----------------------------------------------------------------------------
// accumulator_bank_pkg
//   Shared definitions for the accumulator bank:
//     - state_t  : bank control state (IDLE=0, ACCUM=1, DRAIN=2)
//     - acc_max  : most positive value of a signed accumulator of given width
//     - acc_min  : most negative value of a signed accumulator of given width
//   The helper functions are constant functions so they can size localparams.
// -----------------------------------------------------------------------------
package accumulator_bank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Returned at 64 bits; callers cast down to their accumulator width.
   function automatic logic signed [63:0] acc_max(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] acc_min(input int width);
      return -(64'sd1 <<< (width - 1));
   endfunction

endpackage : accumulator_bank_pkg

// File: rtl/accumulator_bank_if.sv
// -----------------------------------------------------------------------------
// accumulator_bank_if
//   Input beat and output row handshakes of the accumulator bank.
//     in_valid  / in_ready  : input beat handshake
//     in_data               : NUM_CH signed words, lane c at [c*IN_WIDTH +: IN_WIDTH]
//     in_first / in_last    : beat belongs to first / final pass of the tile
//     out_valid / out_ready : drained row handshake
//     out_data              : NUM_CH accumulators, lane c at [c*ACC_WIDTH +: ACC_WIDTH]
//     out_last              : current drained row is the last row of the tile
//   master : upstream producer + downstream consumer side
//   slave  : the accumulator bank
// -----------------------------------------------------------------------------
interface accumulator_bank_if #(
   parameter int NUM_CH    = 4,
   parameter int IN_WIDTH  = 8,
   parameter int ACC_WIDTH = 20
);

   logic                          in_valid;
   logic                          in_ready;
   logic [NUM_CH*IN_WIDTH-1:0]    in_data;
   logic                          in_first;
   logic                          in_last;
   logic                          out_valid;
   logic                          out_ready;
   logic [NUM_CH*ACC_WIDTH-1:0]   out_data;
   logic                          out_last;

   modport master (
      output in_valid, in_data, in_first, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, in_first, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

endinterface : accumulator_bank_if

// File: rtl/accumulator_bank_acc_lane.sv
// -----------------------------------------------------------------------------
// accumulator_bank_acc_lane  (the acc_lane datapath, one per channel)
//   Purely combinational next-value computation for one partial-sum entry.
//   Ports:
//     i_first : overwrite the entry with the sign-extended input
//     i_in    : signed input word
//     i_acc   : current stored partial sum
//     o_acc   : value to write back
//     o_ovf   : the accumulate overflowed (never set on an overwrite)
// -----------------------------------------------------------------------------
module accumulator_bank_acc_lane
   import accumulator_bank_pkg::*;
#(
   parameter int IN_WIDTH  = 8,
   parameter int ACC_WIDTH = 20,
   parameter int SATURATE  = 1
) (
   input  logic                        i_first,
   input  logic signed [IN_WIDTH-1:0]  i_in,
   input  logic signed [ACC_WIDTH-1:0] i_acc,
   output logic signed [ACC_WIDTH-1:0] o_acc,
   output logic                        o_ovf
);

   localparam logic signed [ACC_WIDTH-1:0] LP_MAX = ACC_WIDTH'(acc_max(ACC_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] LP_MIN = ACC_WIDTH'(acc_min(ACC_WIDTH));

   logic signed [ACC_WIDTH:0] w_in_ext;
   logic signed [ACC_WIDTH:0] w_sum;
   logic                      w_sum_ovf;

   // One guard bit above the accumulator: the sum of two in-range values
   // always fits, so a disagreement between the top two bits is an overflow.
   assign w_in_ext  = {{(ACC_WIDTH + 1 - IN_WIDTH){i_in[IN_WIDTH-1]}}, i_in};
   assign w_sum     = {i_acc[ACC_WIDTH-1], i_acc} + w_in_ext;
   assign w_sum_ovf = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

   // NOTE: every output gets a default at the top of always_comb so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      o_acc = w_sum[ACC_WIDTH-1:0];
      o_ovf = 1'b0;
      if (i_first) begin
         o_acc = w_in_ext[ACC_WIDTH-1:0];
      end else begin
         o_ovf = w_sum_ovf;
         // The guard bit carries the true sign of the sum: clamp towards it.
         if (w_sum_ovf && (SATURATE != 0)) begin
            o_acc = w_sum[ACC_WIDTH] ? LP_MIN : LP_MAX;
         end
      end
   end

endmodule : accumulator_bank_acc_lane

// File: rtl/accumulator_bank.sv
// -----------------------------------------------------------------------------
// accumulator_bank
//   Multi-lane output-stationary accumulator. A tile of rows_q rows is
//   accumulated over one or more passes of input beats, then drained row by
//   row. Each lane keeps DEPTH signed partial sums of ACC_WIDTH bits.
//   Ports:
//     clk      : rising-edge clock
//     reset    : synchronous active-high reset of all control state
//     start    : one-cycle pulse, begins a tile (honoured only when idle)
//     cfg_rows : rows per tile, sampled on start; 0 or >DEPTH selects DEPTH
//     bus      : input beat / output row handshakes (slave side)
//     busy     : bank is accumulating or draining
//     ovf      : sticky per-lane overflow, cleared by an accepted start
// -----------------------------------------------------------------------------
module accumulator_bank
   import accumulator_bank_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int IN_WIDTH  = 8,
   parameter int ACC_WIDTH = 20,
   parameter int DEPTH     = 16,
   parameter int PTR_WIDTH = 4,
   parameter int SATURATE  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [PTR_WIDTH:0]   cfg_rows,
   accumulator_bank_if.slave    bus,
   output logic                 busy,
   output logic [NUM_CH-1:0]    ovf
);

   localparam logic [PTR_WIDTH:0]   LP_DEPTH    = (PTR_WIDTH + 1)'(DEPTH);
   localparam logic [PTR_WIDTH:0]   LP_ROWS_ONE = (PTR_WIDTH + 1)'(1);
   localparam logic [PTR_WIDTH-1:0] LP_PTR_ONE  = PTR_WIDTH'(1);

   // Control registers
   state_t                       r_state;
   logic [PTR_WIDTH-1:0]         r_row_ptr;
   logic [PTR_WIDTH-1:0]         r_drain_ptr;
   logic [PTR_WIDTH:0]           r_rows_q;
   logic [NUM_CH-1:0]            r_ovf;
   logic                         r_in_ready;
   logic                         r_out_valid;
   logic                         r_out_last;

   // Partial-sum buffer: one column of DEPTH rows per lane
   logic signed [ACC_WIDTH-1:0]  r_mem [NUM_CH][DEPTH];

   logic                         w_in_fire;
   logic                         w_out_fire;
   logic [PTR_WIDTH:0]           w_rows_clamped;
   logic [PTR_WIDTH-1:0]         w_last_row;
   logic                         w_row_is_last;
   logic signed [ACC_WIDTH-1:0]  w_lane_acc [NUM_CH];
   logic [NUM_CH-1:0]            w_lane_ovf;
   logic [NUM_CH*ACC_WIDTH-1:0]  w_out_row;

   // in_ready / out_valid are only ever high in ACCUM / DRAIN respectively,
   // so the handshakes need no extra state qualification.
   assign w_in_fire  = bus.in_valid & r_in_ready;
   assign w_out_fire = r_out_valid & bus.out_ready;

   assign w_rows_clamped = ((cfg_rows == '0) || (cfg_rows > LP_DEPTH)) ? LP_DEPTH : cfg_rows;
   // rows_q is at least 1 whenever this is used, so the row index fits PTR_WIDTH.
   assign w_last_row     = PTR_WIDTH'(r_rows_q - LP_ROWS_ONE);
   assign w_row_is_last  = (r_row_ptr == w_last_row);

   // ---------------------------------------------------------------------------
   // Per-lane datapath and drain row assembly
   // ---------------------------------------------------------------------------
   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      accumulator_bank_acc_lane #(
         .IN_WIDTH  (IN_WIDTH),
         .ACC_WIDTH (ACC_WIDTH),
         .SATURATE  (SATURATE)
      ) u_lane (
         .i_first (bus.in_first),
         .i_in    (bus.in_data[c*IN_WIDTH +: IN_WIDTH]),
         .i_acc   (r_mem[c][r_row_ptr]),
         .o_acc   (w_lane_acc[c]),
         .o_ovf   (w_lane_ovf[c])
      );

      assign w_out_row[c*ACC_WIDTH +: ACC_WIDTH] = r_mem[c][r_drain_ptr];
   end

   // ---------------------------------------------------------------------------
   // Partial-sum buffer
   // ---------------------------------------------------------------------------
   // NOTE: the buffer has no reset branch on purpose; every tile starts with a
   // first-pass overwrite, so clearing it would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (w_in_fire && !reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_mem[c][r_row_ptr] <= w_lane_acc[c];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM with registered handshake outputs
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_row_ptr   <= '0;
         r_drain_ptr <= '0;
         r_rows_q    <= '0;
         r_ovf       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_rows_q    <= w_rows_clamped;
                  r_row_ptr   <= '0;
                  r_drain_ptr <= '0;
                  r_ovf       <= '0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_ACCUM;
               end
            end

            ST_ACCUM: begin
               if (w_in_fire) begin
                  r_ovf     <= r_ovf | w_lane_ovf;
                  r_row_ptr <= w_row_is_last ? '0 : r_row_ptr + LP_PTR_ONE;
                  // Only the final-pass beat on the tile's last row ends the tile.
                  if (bus.in_last && w_row_is_last) begin
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_out_last  <= (w_last_row == '0);
                     r_drain_ptr <= '0;
                     r_state     <= ST_DRAIN;
                  end
               end
            end

            ST_DRAIN: begin
               if (w_out_fire) begin
                  if (r_out_last) begin
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_state     <= ST_IDLE;
                  end else begin
                     r_drain_ptr <= r_drain_ptr + LP_PTR_ONE;
                     r_out_last  <= ((r_drain_ptr + LP_PTR_ONE) == w_last_row);
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_last  = r_out_last;
   // The buffer row is not written during DRAIN, so the data holds under
   // backpressure without an output register.
   assign bus.out_data  = r_out_valid ? w_out_row : '0;
   assign busy          = (r_state != ST_IDLE);
   assign ovf           = r_ovf;

endmodule : accumulator_bank

// File: tb/tb_accumulator_bank.sv
// -----------------------------------------------------------------------------
// tb_accumulator_bank
//   Three banks driven in lockstep by the same stimulus:
//     a : ACC_WIDTH=20, saturating (default instance)
//     s : ACC_WIDTH=10, saturating
//     w : ACC_WIDTH=10, wrapping
//   A reference model keeps every partial sum as a plain integer and applies
//   the clamp/wrap rule by range comparison after each accepted beat.
// -----------------------------------------------------------------------------
module tb_accumulator_bank;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [4:0] cfg_rows;
   logic       in_valid;
   logic       in_first;
   logic       in_last;
   logic       out_ready;
   logic [31:0] in_data;

   logic       busy_a, busy_s, busy_w;
   logic [3:0] ovf_a, ovf_s, ovf_w;

   always #5 clk = ~clk;

   accumulator_bank_if #(.NUM_CH(4), .IN_WIDTH(8), .ACC_WIDTH(20)) if_a ();
   accumulator_bank_if #(.NUM_CH(4), .IN_WIDTH(8), .ACC_WIDTH(10)) if_s ();
   accumulator_bank_if #(.NUM_CH(4), .IN_WIDTH(8), .ACC_WIDTH(10)) if_w ();

   assign if_a.in_valid = in_valid;  assign if_s.in_valid = in_valid;  assign if_w.in_valid = in_valid;
   assign if_a.in_data  = in_data;   assign if_s.in_data  = in_data;   assign if_w.in_data  = in_data;
   assign if_a.in_first = in_first;  assign if_s.in_first = in_first;  assign if_w.in_first = in_first;
   assign if_a.in_last  = in_last;   assign if_s.in_last  = in_last;   assign if_w.in_last  = in_last;
   assign if_a.out_ready = out_ready; assign if_s.out_ready = out_ready; assign if_w.out_ready = out_ready;

   accumulator_bank #(.ACC_WIDTH(20), .SATURATE(1)) u_dut_a (
      .clk(clk), .reset(reset), .start(start), .cfg_rows(cfg_rows),
      .bus(if_a), .busy(busy_a), .ovf(ovf_a));
   accumulator_bank #(.ACC_WIDTH(10), .SATURATE(1)) u_dut_s (
      .clk(clk), .reset(reset), .start(start), .cfg_rows(cfg_rows),
      .bus(if_s), .busy(busy_s), .ovf(ovf_s));
   accumulator_bank #(.ACC_WIDTH(10), .SATURATE(0)) u_dut_w (
      .clk(clk), .reset(reset), .start(start), .cfg_rows(cfg_rows),
      .bus(if_w), .busy(busy_w), .ovf(ovf_w));

   // ---------------------------------------------------------------------------
   // Reference model state
   // ---------------------------------------------------------------------------
   int         acc_w [3] = '{20, 10, 10};
   bit         sat_v [3] = '{1'b1, 1'b1, 1'b0};
   longint     m_acc [3][4][16];
   logic [3:0] m_ovf [3];
   int         m_rows;
   int         m_row;
   int         beat_d [4];
   logic [127:0] got_a, got_s, got_w;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Next value of one model entry; wrap subtracts/adds one full period.
   function automatic longint step_model(input int k, input longint old_v, input longint x,
                                         input bit first, output bit ov);
      longint span;
      longint hi;
      longint lo;
      longint s;
      span = 64'sd1 <<< acc_w[k];
      hi   = span / 2 - 1;
      lo   = -(span / 2);
      ov   = 1'b0;
      if (first) return x;
      s = old_v + x;
      if (s > hi) begin
         ov = 1'b1;
         return sat_v[k] ? hi : s - span;
      end
      if (s < lo) begin
         ov = 1'b1;
         return sat_v[k] ? lo : s + span;
      end
      return s;
   endfunction

   function automatic logic [127:0] exp_row(input int k, input int r);
      logic [127:0] v;
      logic [127:0] mask;
      v    = '0;
      mask = (128'd1 << acc_w[k]) - 128'd1;
      for (int c = 0; c < 4; c++) begin
         v |= ((128'(m_acc[k][c][r])) & mask) << (c * acc_w[k]);
      end
      return v;
   endfunction

   // Called at a negedge with the bank idle.
   task automatic do_start(input int rows);
      start    = 1'b1;
      cfg_rows = rows[4:0];
      @(negedge clk);
      start    = 1'b0;
      m_rows   = (rows == 0 || rows > 16) ? 16 : rows;
      m_row    = 0;
      for (int k = 0; k < 3; k++) m_ovf[k] = 4'h0;
      check("busy_after_start", busy_a, 1'b1);
      check("in_ready_after_start", if_a.in_ready, 1'b1);
   endtask

   // Presents beat_d with the given flags and returns after it is accepted.
   task automatic send_beat(input bit first, input bit last);
      int cnt;
      bit ov;
      in_valid = 1'b1;
      in_first = first;
      in_last  = last;
      for (int c = 0; c < 4; c++) in_data[c*8 +: 8] = beat_d[c][7:0];
      cnt = 0;
      while (!if_a.in_ready && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check("in_ready_wait", if_a.in_ready, 1'b1);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         for (int c = 0; c < 4; c++) begin
            m_acc[k][c][m_row] = step_model(k, m_acc[k][c][m_row], longint'(beat_d[c]), first, ov);
            if (ov) m_ovf[k][c] = 1'b1;
         end
      end
      m_row = (m_row + 1) % m_rows;
   endtask

   task automatic drain_tile(input int stall_row, input int start_row);
      int cnt;
      for (int r = 0; r < m_rows; r++) begin
         cnt = 0;
         while (!if_a.out_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
         end
         check("out_valid", if_a.out_valid, 1'b1);
         check("in_ready_in_drain", if_a.in_ready, 1'b0);
         check("out_last", if_a.out_last, (r == m_rows - 1));
         check("row_a", if_a.out_data, exp_row(0, r));
         check("row_s", if_s.out_data, exp_row(1, r));
         check("row_w", if_w.out_data, exp_row(2, r));
         got_a = if_a.out_data;
         got_s = if_s.out_data;
         got_w = if_w.out_data;
         if (r == stall_row) begin
            out_ready = 1'b0;
            repeat (4) begin
               @(negedge clk);
               check("stall_data", if_a.out_data, exp_row(0, r));
               check("stall_last", if_a.out_last, (r == m_rows - 1));
            end
         end
         if (r == start_row) begin
            start    = 1'b1;
            cfg_rows = 5'd5;
         end
         out_ready = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      out_ready = 1'b0;
      check("valid_after_drain", if_a.out_valid, 1'b0);
      check("last_after_drain", if_a.out_last, 1'b0);
      check("data_zero_after_drain", if_a.out_data, '0);
      check("busy_after_drain", busy_a, 1'b0);
      check("ovf_a", ovf_a, m_ovf[0]);
      check("ovf_s", ovf_s, m_ovf[1]);
      check("ovf_w", ovf_w, m_ovf[2]);
   endtask

   // mode 0: every lane carries cval; mode 1: random words.
   task automatic run_tile(input int rows_cfg, input int passes, input int mode, input int cval,
                           input bit mix, input int stall_row, input bit hold_valid);
      bit first;
      bit last;
      do_start(rows_cfg);
      for (int p = 0; p < passes; p++) begin
         for (int r = 0; r < m_rows; r++) begin
            for (int c = 0; c < 4; c++)
               beat_d[c] = (mode == 0) ? cval : int'($urandom_range(255)) - 128;
            first = (p == 0) ? 1'b1 : (mix && ($urandom_range(7) == 0));
            if (r == m_rows - 1) last = (p == passes - 1);
            else                 last = mix && ($urandom_range(1) == 1);
            if (mix && ($urandom_range(3) == 0)) begin
               in_valid = 1'b0;
               @(negedge clk);
            end
            send_beat(first, last);
         end
      end
      in_valid = hold_valid;
      check("in_ready_after_tile", if_a.in_ready, 1'b0);
      check("valid_after_tile", if_a.out_valid, 1'b1);
      drain_tile(stall_row, -1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      cfg_rows  = '0;
      in_valid  = 1'b0;
      in_first  = 1'b0;
      in_last   = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_busy", busy_a, 1'b0);
      check("rst_in_ready", if_a.in_ready, 1'b0);
      check("rst_out_valid", if_a.out_valid, 1'b0);
      check("rst_out_last", if_a.out_last, 1'b0);
      check("rst_out_data", if_a.out_data, '0);
      check("rst_ovf", ovf_a, 4'h0);

      // Single pass, two rows, first=last on both beats
      do_start(2);
      beat_d = '{1, 2, 3, 4};
      send_beat(1'b1, 1'b1);
      beat_d = '{-1, -2, -3, -4};
      send_beat(1'b1, 1'b1);
      in_valid = 1'b0;
      drain_tile(-1, -1);
      check("t1_row1_lane3", longint'($signed(got_a[79:60])), -64'sd4);

      // Three passes of 5 over three rows
      run_tile(3, 3, 0, 5, 1'b0, -1, 1'b0);
      check("t2_row_value", longint'($signed(got_a[19:0])), 64'sd15);

      // Positive saturation / wrap
      run_tile(1, 5, 0, 127, 1'b0, -1, 1'b0);
      check("sat_pos_a", longint'($signed(got_a[19:0])), 64'sd635);
      check("sat_pos_s", longint'($signed(got_s[9:0])), 64'sd511);
      check("wrap_pos_w", longint'($signed(got_w[9:0])), -64'sd389);
      check("sat_pos_ovf_s", ovf_s, 4'hF);
      check("wrap_pos_ovf_w", ovf_w, 4'hF);
      check("sat_pos_ovf_a", ovf_a, 4'h0);

      // Negative saturation / wrap
      run_tile(1, 5, 0, -128, 1'b0, -1, 1'b0);
      check("sat_neg_s", longint'($signed(got_s[9:0])), -64'sd512);
      check("wrap_neg_w", longint'($signed(got_w[9:0])), 64'sd384);
      check("sat_neg_a", longint'($signed(got_a[19:0])), -64'sd640);

      // cfg_rows=0 -> 16 rows, backpressure mid-drain, in_valid held high
      run_tile(0, 1, 1, 0, 1'b0, 5, 1'b1);
      @(negedge clk);
      check("idle_in_ready_with_valid", if_a.in_ready, 1'b0);
      in_valid = 1'b0;

      // Randomised multi-pass tiles with mixed flags, gaps and stalls
      for (int t = 0; t < 6; t++) begin
         run_tile(int'($urandom_range(31)), int'($urandom_range(1, 4)), 1, 0, 1'b1,
                  int'($urandom_range(15)), 1'b0);
      end

      // Reset mid-ACCUM aborts the tile
      do_start(4);
      beat_d = '{100, 100, 100, 100};
      send_beat(1'b1, 1'b0);
      send_beat(1'b1, 1'b0);
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", busy_a, 1'b0);
      check("abort_in_ready", if_a.in_ready, 1'b0);
      check("abort_out_valid", if_a.out_valid, 1'b0);

      // New tile yields only new data; start pulsed during DRAIN is ignored
      do_start(2);
      beat_d = '{7, -7, 64, -100};
      send_beat(1'b1, 1'b1);
      beat_d = '{-50, 50, 3, 9};
      send_beat(1'b1, 1'b1);
      in_valid = 1'b0;
      drain_tile(-1, 0);
      check("new_tile_row1_lane0", longint'($signed(got_a[19:0])), -64'sd50);

      // Reset mid-DRAIN aborts the drain
      run_tile(3, 1, 1, 0, 1'b0, -1, 1'b0);
      do_start(3);
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) beat_d[c] = int'($urandom_range(255)) - 128;
         send_beat(1'b1, 1'b1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      check("drain_abort_valid", if_a.out_valid, 1'b0);
      check("drain_abort_busy", busy_a, 1'b0);
      check("drain_abort_data", if_a.out_data, '0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule : tb_accumulator_bank
